sram_arbiter: RTL and testbench

Merges the CPU's separate instruction and data SRAM ports onto one single-port synchronous RAM, downstream of `mycpu_pipeline`. Same-cycle conflicts are resolved data-first. The losing instruction fetch is replayed in a one-cycle freeze signalled on `stallreq_outside`. Per-port read-data hold registers keep every response stable until the port's next response, so frozen pipeline stages still capture correct data.

---
 rtl/sram_arbiter_pkg.sv | 18 +
 rtl/sram_resp_hold.sv | 34 +++
 rtl/sram_arbiter.sv | 137 +++++++++++++
 tb/tb_sram_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg
// Shared type definitions for the instruction/data SRAM arbiter.
//   arb_state_t : arbiter FSM state (idle, or replaying a fetch that lost a conflict)
//   resp_sel_t  : which CPU port owns the RAM read data returning this cycle
package sram_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_REPLAY = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_INST = 2'd1,
      RESP_DATA = 2'd2
   } resp_sel_t;

endpackage

// File: rtl/sram_resp_hold.sv
// sram_resp_hold
// Keeps one CPU port's read data stable between responses. In the cycle a
// response returns, the RAM data passes straight through and is captured;
// in every other cycle the captured value is presented.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears the held value to 0
//   load  : a response for this port returns in the current cycle
//   din   : RAM read data
//   dout  : read data presented to the CPU port
module sram_resp_hold (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] din,
   output logic [31:0] dout
);

   logic [31:0] hold_q;

   // Capture the response on its return cycle. Reset takes priority, so a
   // response that arrives while reset is asserted is discarded.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
      end else if (load) begin
         hold_q <= din;
      end
   end

   // Bypass so the response is visible in the same cycle it returns from RAM.
   assign dout = load ? din : hold_q;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
// Merges the CPU instruction and data SRAM ports onto one single-port
// synchronous RAM. Data wins a same-cycle conflict; the losing fetch is
// replayed in the following cycle while stallreq_outside freezes the CPU.
// Ports:
//   clk, rst_n                : clock and synchronous active-low reset
//   inst_sram_*               : read-only instruction port (we/wdata ignored)
//   data_sram_*               : data port, we == 0 means read
//   stallreq_outside          : high during the single replay cycle
//   ram_en/we/addr/wdata      : single-port RAM request (word address)
//   ram_rdata                 : RAM read data, valid the cycle after a read
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              inst_sram_en,
   input  logic [3:0]        inst_sram_we,
   input  logic [31:0]       inst_sram_addr,
   input  logic [31:0]       inst_sram_wdata,
   output logic [31:0]       inst_sram_rdata,
   input  logic              data_sram_en,
   input  logic [3:0]        data_sram_we,
   input  logic [31:0]       data_sram_addr,
   input  logic [31:0]       data_sram_wdata,
   output logic [31:0]       data_sram_rdata,
   output logic              stallreq_outside,
   output logic              ram_en,
   output logic [3:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   arb_state_t        state;
   resp_sel_t         resp_sel;
   logic [ADDR_W-1:0] pend_addr;
   logic [ADDR_W-1:0] inst_word;
   logic [ADDR_W-1:0] data_word;
   logic              unused_bits;

   assign inst_word = inst_sram_addr[ADDR_W+1:2];
   assign data_word = data_sram_addr[ADDR_W+1:2];

   // The instruction port is read-only and only the word-address bits of
   // each byte address reach the RAM; fold the rest away explicitly.
   assign unused_bits = ^{inst_sram_we, inst_sram_wdata, inst_sram_addr, data_sram_addr};

   // Arbiter FSM. A conflict serves the data access now and parks the fetch
   // address for the replay cycle. resp_sel records which port the RAM data
   // returning next cycle belongs to; writes return nothing.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ARB_IDLE;
         resp_sel  <= RESP_NONE;
         pend_addr <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (data_sram_en) begin
                  resp_sel <= (data_sram_we == 4'b0000) ? RESP_DATA : RESP_NONE;
                  if (inst_sram_en) begin
                     pend_addr <= inst_word;
                     state     <= ARB_REPLAY;
                  end
               end else if (inst_sram_en) begin
                  resp_sel <= RESP_INST;
               end else begin
                  resp_sel <= RESP_NONE;
               end
            end
            ARB_REPLAY: begin
               resp_sel <= RESP_INST;
               state    <= ARB_IDLE;
            end
            default: begin
               resp_sel <= RESP_NONE;
               state    <= ARB_IDLE;
            end
         endcase
      end
   end

   // The CPU is frozen for exactly the cycles spent replaying, so the stall
   // is simply the registered state.
   assign stallreq_outside = (state == ARB_REPLAY);

   // RAM request, combinational from the CPU requests and state. Nothing is
   // issued while reset is asserted, which also drops a pending replay.
   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 4'b0000;
      ram_addr  = '0;
      ram_wdata = '0;
      if (rst_n) begin
         case (state)
            ARB_IDLE: begin
               if (data_sram_en) begin
                  ram_en    = 1'b1;
                  ram_we    = data_sram_we;
                  ram_addr  = data_word;
                  ram_wdata = data_sram_wdata;
               end else if (inst_sram_en) begin
                  ram_en   = 1'b1;
                  ram_addr = inst_word;
               end
            end
            ARB_REPLAY: begin
               ram_en   = 1'b1;
               ram_addr = pend_addr;
            end
            default: begin
               ram_en = 1'b0;
            end
         endcase
      end
   end

   sram_resp_hold u_inst_hold (
      .clk  (clk),
      .rst_n(rst_n),
      .load (resp_sel == RESP_INST),
      .din  (ram_rdata),
      .dout (inst_sram_rdata)
   );

   sram_resp_hold u_data_hold (
      .clk  (clk),
      .rst_n(rst_n),
      .load (resp_sel == RESP_DATA),
      .din  (ram_rdata),
      .dout (data_sram_rdata)
   );

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
// Directed bench for sram_arbiter with a behavioural single-port RAM and a
// scoreboard of expected per-port read responses.
module tb_sram_arbiter;

   localparam int ADDR_W = 16;
   localparam logic [31:0] WORD_A = 32'hA5A5_0008;
   localparam logic [31:0] WORD_B = 32'hB6B6_0016;

   typedef struct {
      int          due;
      logic [31:0] val;
   } resp_t;

   logic              clk;
   logic              rst_n;
   logic              inst_sram_en;
   logic [3:0]        inst_sram_we;
   logic [31:0]       inst_sram_addr;
   logic [31:0]       inst_sram_wdata;
   logic [31:0]       inst_sram_rdata;
   logic              data_sram_en;
   logic [3:0]        data_sram_we;
   logic [31:0]       data_sram_addr;
   logic [31:0]       data_sram_wdata;
   logic [31:0]       data_sram_rdata;
   logic              stallreq_outside;
   logic              ram_en;
   logic [3:0]        ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int tests;
   int fails;
   int cyc;

   resp_t       inst_q[$];
   resp_t       data_q[$];
   logic [31:0] exp_inst;
   logic [31:0] exp_data;
   logic        m_replay;
   logic        m_replay_next;
   logic [9:0]  m_pend;
   logic [31:0] ref_mem[1024];
   bit          ref_valid[1024];

   logic [31:0] ram_mem[1024];
   bit          ram_valid[1024];
   logic [31:0] ram_cur;

   sram_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_we    (inst_sram_we),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_wdata (inst_sram_wdata),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_we    (data_sram_we),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .stallreq_outside(stallreq_outside),
      .ram_en          (ram_en),
      .ram_we          (ram_we),
      .ram_addr        (ram_addr),
      .ram_wdata       (ram_wdata),
      .ram_rdata       (ram_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Power-on contents of the RAM, shared by the RAM model and the reference.
   function automatic logic [31:0] init_val(input int idx);
      case (idx)
         4:       return 32'h1234_5678;
         8:       return WORD_A;
         16:      return WORD_B;
         default: return 32'h5000_0000 | idx;
      endcase
   endfunction

   function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   // Behavioural single-port synchronous RAM with byte enables.
   always @(posedge clk) begin
      if (ram_en) begin
         ram_cur = ram_valid[ram_addr[9:0]] ? ram_mem[ram_addr[9:0]] : init_val(int'(ram_addr[9:0]));
         if (ram_we != 4'b0000) begin
            ram_mem[ram_addr[9:0]]   <= merge_bytes(ram_cur, ram_wdata, ram_we);
            ram_valid[ram_addr[9:0]] <= 1'b1;
         end else begin
            ram_rdata <= ram_cur;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation did not complete");
   end

   function automatic logic [31:0] ref_read(input logic [9:0] idx);
      return ref_valid[idx] ? ref_mem[idx] : init_val(int'(idx));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      m_replay = m_replay_next;
      #1;
   endtask

   // Drive one cycle of CPU requests, predict the arbiter's behaviour from
   // the reference memory, then check everything at the falling edge.
   task automatic apply_step(input logic ie, input logic [3:0] iwe, input logic [31:0] ia,
                             input logic de, input logic [3:0] dwe, input logic [31:0] da,
                             input logic [31:0] dwd);
      logic        exp_en;
      logic [3:0]  exp_we;
      logic [15:0] exp_addr;
      logic [31:0] exp_wd;
      logic        exp_stall;
      resp_t       r;
      exp_en        = 1'b0;
      exp_we        = 4'b0000;
      exp_addr      = 16'h0000;
      exp_wd        = 32'h0;
      exp_stall     = m_replay;
      m_replay_next = 1'b0;
      if (m_replay) begin
         exp_en   = 1'b1;
         exp_addr = {6'b0, m_pend};
         r.due    = cyc + 1;
         r.val    = ref_read(m_pend);
         inst_q.push_back(r);
      end else if (de) begin
         exp_en   = 1'b1;
         exp_addr = da[17:2];
         exp_we   = dwe;
         exp_wd   = dwd;
         if (dwe == 4'b0000) begin
            r.due = cyc + 1;
            r.val = ref_read(da[11:2]);
            data_q.push_back(r);
         end else begin
            ref_mem[da[11:2]]   = merge_bytes(ref_read(da[11:2]), dwd, dwe);
            ref_valid[da[11:2]] = 1'b1;
         end
         if (ie) begin
            m_replay_next = 1'b1;
            m_pend        = ia[11:2];
         end
      end else if (ie) begin
         exp_en   = 1'b1;
         exp_addr = ia[17:2];
         r.due    = cyc + 1;
         r.val    = ref_read(ia[11:2]);
         inst_q.push_back(r);
      end

      inst_sram_en    = ie;
      inst_sram_we    = iwe;
      inst_sram_addr  = ia;
      inst_sram_wdata = 32'hDEAD_BEEF;
      data_sram_en    = de;
      data_sram_we    = dwe;
      data_sram_addr  = da;
      data_sram_wdata = dwd;

      @(negedge clk);
      if (inst_q.size() > 0 && inst_q[0].due == cyc) exp_inst = inst_q.pop_front().val;
      if (data_q.size() > 0 && data_q[0].due == cyc) exp_data = data_q.pop_front().val;
      check("stall", {31'b0, stallreq_outside}, {31'b0, exp_stall});
      check("ram_en", {31'b0, ram_en}, {31'b0, exp_en});
      check("ram_we", {28'b0, ram_we}, {28'b0, exp_we});
      if (exp_en) check("ram_addr", {16'b0, ram_addr}, {16'b0, exp_addr});
      if (exp_we != 4'b0000) check("ram_wdata", ram_wdata, exp_wd);
      check("inst_rdata", inst_sram_rdata, exp_inst);
      check("data_rdata", data_sram_rdata, exp_data);
   endtask

   task automatic idle_step();
      apply_step(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
   endtask

   task automatic model_reset();
      inst_q.delete();
      data_q.delete();
      exp_inst      = 32'h0;
      exp_data      = 32'h0;
      m_replay      = 1'b0;
      m_replay_next = 1'b0;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      cyc   = 0;
      m_pend = '0;
      model_reset();
      rst_n           = 1'b0;
      inst_sram_en    = 1'b0;
      inst_sram_we    = 4'h0;
      inst_sram_addr  = 32'h0;
      inst_sram_wdata = 32'h0;
      data_sram_en    = 1'b0;
      data_sram_we    = 4'h0;
      data_sram_addr  = 32'h0;
      data_sram_wdata = 32'h0;

      // Reset state
      @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_stall", {31'b0, stallreq_outside}, 32'h0);
      check("reset_ram_en", {31'b0, ram_en}, 32'h0);
      check("reset_ram_we", {28'b0, ram_we}, 32'h0);
      check("reset_inst_rdata", inst_sram_rdata, 32'h0);
      check("reset_data_rdata", data_sram_rdata, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Uncontended fetch, with the instruction port trying to write
      apply_step(1'b1, 4'hF, 32'h0000_0010, 1'b0, 4'h0, 32'h0, 32'h0);
      check("fetch_ram_addr", {16'b0, ram_addr}, 32'd4);
      check("inst_we_ignored", {28'b0, ram_we}, 32'h0);
      tick();
      idle_step();
      check("fetch_rdata", inst_sram_rdata, 32'h1234_5678);
      check("fetch_no_stall", {31'b0, stallreq_outside}, 32'h0);
      tick();

      // Read conflict; inputs during the replay cycle must be ignored
      apply_step(1'b1, 4'h0, 32'h0000_0020, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      check("conflict_n_addr", {16'b0, ram_addr}, 32'd16);
      tick();
      apply_step(1'b1, 4'h0, 32'h0000_0010, 1'b1, 4'hF, 32'h0000_0008, 32'h0BAD_0BAD);
      check("conflict_n1_addr", {16'b0, ram_addr}, 32'd8);
      check("conflict_n1_stall", {31'b0, stallreq_outside}, 32'h1);
      check("conflict_n1_data", data_sram_rdata, WORD_B);
      tick();
      idle_step();
      check("conflict_n2_inst", inst_sram_rdata, WORD_A);
      check("conflict_n2_stall", {31'b0, stallreq_outside}, 32'h0);
      check("conflict_n2_data", data_sram_rdata, WORD_B);
      tick();

      // Write conflict: data hold must keep its previous value
      apply_step(1'b1, 4'h0, 32'h0000_0010, 1'b1, 4'b0011, 32'h0000_0040, 32'hAAAA_BBBB);
      check("wconf_ram_we", {28'b0, ram_we}, 32'h3);
      tick();
      idle_step();
      check("wconf_data_held", data_sram_rdata, WORD_B);
      tick();
      idle_step();
      tick();
      apply_step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0040, 32'h0);
      tick();
      idle_step();
      check("wconf_readback", data_sram_rdata, 32'hB6B6_BBBB);
      tick();

      // Back-to-back conflicts
      apply_step(1'b1, 4'h0, 32'h0000_0020, 1'b1, 4'h0, 32'h0000_0010, 32'h0);
      tick();
      idle_step();
      check("b2b_n1_stall", {31'b0, stallreq_outside}, 32'h1);
      tick();
      apply_step(1'b1, 4'h0, 32'h0000_0040, 1'b1, 4'h0, 32'h0000_0020, 32'h0);
      check("b2b_n2_stall", {31'b0, stallreq_outside}, 32'h0);
      check("b2b_n2_inst", inst_sram_rdata, WORD_A);
      tick();
      idle_step();
      check("b2b_n3_stall", {31'b0, stallreq_outside}, 32'h1);
      check("b2b_n3_data", data_sram_rdata, WORD_A);
      tick();
      idle_step();
      check("b2b_n4_stall", {31'b0, stallreq_outside}, 32'h0);
      check("b2b_n4_inst", inst_sram_rdata, 32'hB6B6_BBBB);
      tick();

      // Write then read of the same word on consecutive cycles
      apply_step(1'b0, 4'h0, 32'h0, 1'b1, 4'hF, 32'h0000_0080, 32'h0F1E_2D3C);
      tick();
      apply_step(1'b0, 4'h0, 32'h0, 1'b1, 4'h0, 32'h0000_0080, 32'h0);
      tick();
      idle_step();
      check("wr_then_rd", data_sram_rdata, 32'h0F1E_2D3C);
      tick();

      // Reset asserted in the replay cycle
      apply_step(1'b1, 4'h0, 32'h0000_0010, 1'b1, 4'h0, 32'h0000_0008, 32'h0);
      tick();
      rst_n           = 1'b0;
      inst_sram_en    = 1'b0;
      data_sram_en    = 1'b0;
      data_sram_we    = 4'h0;
      @(posedge clk);
      cyc++;
      #1;
      rst_n = 1'b1;
      model_reset();
      idle_step();
      check("rst_replay_stall", {31'b0, stallreq_outside}, 32'h0);
      check("rst_replay_ram_en", {31'b0, ram_en}, 32'h0);
      check("rst_replay_inst", inst_sram_rdata, 32'h0);
      check("rst_replay_data", data_sram_rdata, 32'h0);
      tick();

      // Normal operation resumes after reset
      apply_step(1'b1, 4'h0, 32'h0000_0020, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      idle_step();
      tick();

      check("inst_q_drained", inst_q.size(), 32'd0);
      check("data_q_drained", data_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
